pipelined_control_path: RTL and testbench
=========================================

Name: pipelined_control_path

Overview:
- Five-stage (F/D/E/M/W) successor to the single-cycle control path.
- Decodes InstrD in Decode and carries control bundles through D/E, E/M and M/W registers.
- Resolves branches and jumps in Execute, where PCSrcE is produced.
- Contains the hazard unit: load-use and RAW stalls, branch flushes, and forwarding selects for the datapath.

Parameters:
- REG_ADDR_W, 5, register-index width.
- FORWARDING, 1, 1 = M/W→E forwarding enabled; 0 = no forwarding, every RAW resolved by stalling.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see Behaviour).
- InstrD  in  32  instruction in Decode.
- ZeroE  in  1  ALU result == 0 in Execute.
- ImmSrcD  out  3  I=000 S=001 B=010 J=011 U=100.
- ALUControlE  out  4  ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 PASSB10.
- ALUSrcAE  out  1  1 = PC, 0 = rs1.
- ALUSrcBE  out  1  1 = imm, 0 = rs2.
- PCSrcE  out  2  00 = PC+4, 01 = PC+imm, 10 = ALUResult.
- MemWriteM  out  1  data-memory write enable.
- AddressingControlM  out  3  funct3 of load/store.
- RegWriteW  out  1  register-file write enable.
- ResultSrcW  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- RdW  out  REG_ADDR_W  writeback register index.
- StallF, StallD  out  1  hold PC / IF-ID register.
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALUResult.
- IllegalE  out  1  Execute holds an unsupported opcode.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high.
- On rst, every pipeline register is loaded with the bubble: all enables 0, PCSrc 00, Rd 0, Illegal 0. Every output is therefore 0.
- Decode is combinational from InstrD and covers RV32I: R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC.
- Any other opcode decodes to a bubble with Illegal=1.
- Branch ALU op: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
- Branch taken when: BEQ and ZeroE; BNE, BLT or BLTU and !ZeroE; BGE or BGEU and ZeroE.
- PCSrcE: 01 for JAL or a taken branch; 10 for JALR; else 00. Gated to 00 when the E bundle is a bubble.
- Latency: an instruction's E controls appear 1 cycle after it is in D, M controls after 2, W controls after 3.
- Forwarding, when FORWARDING=1:
  - ForwardAE=10 if RegWriteM, RdM≠0 and RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW, RdW≠0 and RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - When FORWARDING=0 both are tied to 00.
- Only rs fields actually used by the D-stage format count for hazards (no rs2 for I/U/J, no rs1 for U/J).
- Load-use stall: ResultSrcE==01, RdE≠0 and RdE matches a used Rs of D. Asserts StallF=StallD=FlushE for 1 cycle.
- FORWARDING=0: additionally stall while RdE or RdM (RegWrite set, ≠0) matches a used Rs of D. Stall lasts 1–2 cycles; W is assumed write-first in the regfile.
- Taken control transfer (PCSrcE≠00): FlushD=FlushE=1 that cycle, and Stall* is forced to 0. Flush has priority over stall.
- FlushE or rst loads a bubble into D/E. E/M and M/W always advance; no back-pressure.
- Stall holds nothing inside this block except that D/E receives a bubble. Rs1E, Rs2E and RdE are registered from InstrD fields.
- x0: writes to Rd=0 never generate forwarding or stalls.
- rst asserted mid-operation clears all stages immediately. The first post-reset cycle drives PCSrcE=00 and no stalls.

Test Plan:
- rst pulse mid-stream with a load in E → all outputs 0 asynchronously; after release, pipeline flows with no spurious stall or flush.
- add x5,x1,x2 then sub x6,x5,x3 → ForwardAE=10 for the sub in E. Insert 1 nop between them → ForwardAE=01. With FORWARDING=0 → StallD high 2 cycles, Forward*=00.
- lw x7,0(x1) then add x8,x7,x7 → StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=ForwardBE=01.
- beq taken (ZeroE=1) → PCSrcE=01, FlushD=FlushE=1. Same with ZeroE=0 → PCSrcE=00, no flush. bge with ZeroE=1 → taken.
- jalr x1,0(x2) → PCSrcE=10, ResultSrcW=10 three cycles later, RegWriteW=1, RdW=1.
- Opcode 0x7F → IllegalE=1 one cycle later, with RegWriteW=MemWriteM=0 downstream. addi x0,x0,1 followed by a use of x0 → no forwarding, no stall.

Source files
------------

// File: rtl/pipelined_control_path.sv
// pipelined_control_path: five-stage RV32I control path with D/E, E/M, M/W control registers and hazard unit
// Ports: clk, rst (async, active-high); InstrD, ZeroE in; ImmSrcD decoded in D; ALUControlE/ALUSrcAE/ALUSrcBE/PCSrcE/IllegalE
// from D/E; MemWriteM/AddressingControlM from E/M; RegWriteW/ResultSrcW/RdW from M/W; StallF/StallD/FlushD/FlushE and
// ForwardAE/ForwardBE from the hazard unit.
module pipelined_control_path #(
    parameter int REG_ADDR_W = 5,
    parameter bit FORWARDING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           InstrD,
    input  logic                  ZeroE,
    output logic [2:0]            ImmSrcD,
    output logic [3:0]            ALUControlE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic [1:0]            PCSrcE,
    output logic                  MemWriteM,
    output logic [2:0]            AddressingControlM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  IllegalE
);
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [3:0]            alu_ctrl;
        logic                  src_a;
        logic                  src_b;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic [2:0]            f3;
        logic [2:0]            addr_ctrl;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  illegal;
    } de_t;
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [2:0]            addr_ctrl;
        logic [REG_ADDR_W-1:0] rd;
    } em_t;
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [REG_ADDR_W-1:0] rd;
    } mw_t;
    de_t de_q, de_d, dec;
    em_t em_q, em_d;
    mw_t mw_q, mw_d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] alu_op, br_alu;
    logic [REG_ADDR_W-1:0] rs1_d, rs2_d;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
    logic use_rs1, use_rs2, hit_e, hit_m, lw_stall, raw_stall, taken, flush, stall;
    logic unused_bits;
    assign op          = InstrD[6:0];
    assign f3          = InstrD[14:12];
    assign rs1_d       = REG_ADDR_W'(InstrD[19:15]);
    assign rs2_d       = REG_ADDR_W'(InstrD[24:20]);
    assign unused_bits = ^{InstrD[31], InstrD[29:25]};
    assign is_r     = op == 7'b0110011;
    assign is_i     = op == 7'b0010011;
    assign is_ld    = op == 7'b0000011;
    assign is_st    = op == 7'b0100011;
    assign is_br    = op == 7'b1100011;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111;
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign legal    = |{is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc};
    assign use_rs1  = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    assign use_rs2  = is_r | is_st | is_br;
    // Only R-type distinguishes ADD/SUB by funct7; shifts use bit 30 for both R and I.
    assign alu_op = f3 == 3'b000 ? ((is_r && InstrD[30]) ? 4'd1 : 4'd0) :
                    f3 == 3'b001 ? 4'd5 :
                    f3 == 3'b010 ? 4'd8 :
                    f3 == 3'b011 ? 4'd9 :
                    f3 == 3'b100 ? 4'd4 :
                    f3 == 3'b101 ? (InstrD[30] ? 4'd7 : 4'd6) :
                    f3 == 3'b110 ? 4'd3 : 4'd2;
    assign br_alu  = f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1;
    assign ImmSrcD = is_st ? 3'b001 : is_br ? 3'b010 : is_jal ? 3'b011 : (is_lui | is_auipc) ? 3'b100 : 3'b000;
    always_comb begin
        dec            = '0;
        dec.reg_write  = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
        dec.result_src = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
        dec.mem_write  = is_st;
        dec.alu_ctrl   = (is_r | is_i) ? alu_op : is_br ? br_alu : is_lui ? 4'd10 : 4'd0;
        dec.src_a      = is_auipc;
        dec.src_b      = is_i | is_ld | is_st | is_jalr | is_lui | is_auipc;
        dec.branch     = is_br;
        dec.jal        = is_jal;
        dec.jalr       = is_jalr;
        dec.f3         = legal ? f3 : 3'b000;
        dec.addr_ctrl  = (is_ld | is_st) ? f3 : 3'b000;
        dec.rd         = legal ? REG_ADDR_W'(InstrD[11:7]) : '0;
        dec.rs1        = legal ? rs1_d : '0;
        dec.rs2        = legal ? rs2_d : '0;
        dec.illegal    = !legal;
    end
    // Hazard detection only looks at source fields the D-stage format really reads.
    assign hit_e = de_q.rd != '0 && ((use_rs1 && rs1_d == de_q.rd) || (use_rs2 && rs2_d == de_q.rd));
    assign hit_m = em_q.rd != '0 && ((use_rs1 && rs1_d == em_q.rd) || (use_rs2 && rs2_d == em_q.rd));
    assign lw_stall  = de_q.result_src == 2'b01 && hit_e;
    // Without forwarding, wait until the producer reaches W (regfile writes before it reads).
    assign raw_stall = !FORWARDING && ((de_q.reg_write && hit_e) || (em_q.reg_write && hit_m));
    assign taken = de_q.branch && ((de_q.f3 == 3'b000 || de_q.f3 == 3'b101 || de_q.f3 == 3'b111) ? ZeroE :
                                   (de_q.f3 == 3'b001 || de_q.f3 == 3'b100 || de_q.f3 == 3'b110) ? !ZeroE : 1'b0);
    assign PCSrcE = de_q.jalr ? 2'b10 : (de_q.jal || taken) ? 2'b01 : 2'b00;
    assign flush  = PCSrcE != 2'b00;
    assign stall  = !flush && (lw_stall || raw_stall);
    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = flush;
    assign FlushE = flush || stall;
    assign ForwardAE = (FORWARDING && em_q.reg_write && em_q.rd != '0 && em_q.rd == de_q.rs1) ? 2'b10 :
                       (FORWARDING && mw_q.reg_write && mw_q.rd != '0 && mw_q.rd == de_q.rs1) ? 2'b01 : 2'b00;
    assign ForwardBE = (FORWARDING && em_q.reg_write && em_q.rd != '0 && em_q.rd == de_q.rs2) ? 2'b10 :
                       (FORWARDING && mw_q.reg_write && mw_q.rd != '0 && mw_q.rd == de_q.rs2) ? 2'b01 : 2'b00;
    assign de_d = FlushE ? '0 : dec;
    assign em_d = '{reg_write: de_q.reg_write, result_src: de_q.result_src, mem_write: de_q.mem_write,
                    addr_ctrl: de_q.addr_ctrl, rd: de_q.rd};
    assign mw_d = '{reg_write: em_q.reg_write, result_src: em_q.result_src, rd: em_q.rd};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
        end else begin
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
        end
    end
    assign ALUControlE        = de_q.alu_ctrl;
    assign ALUSrcAE           = de_q.src_a;
    assign ALUSrcBE           = de_q.src_b;
    assign IllegalE           = de_q.illegal;
    assign MemWriteM          = em_q.mem_write;
    assign AddressingControlM = em_q.addr_ctrl;
    assign RegWriteW          = mw_q.reg_write;
    assign ResultSrcW         = mw_q.result_src;
    assign RdW                = mw_q.rd;
endmodule

// File: tb/tb_pipelined_control_path.sv
// tb_pipelined_control_path: directed checks of decode, pipelining, hazards and forwarding with and without forwarding
module tb_pipelined_control_path;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADD5  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
    localparam logic [31:0] SUB6  = {7'b0100000, 5'd3, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LW7   = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] ADD8  = {7'b0000000, 5'd7, 5'd7, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] BEQ   = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] BGE   = {7'b0000000, 5'd2, 5'd1, 3'b101, 5'd0, 7'b1100011};
    localparam logic [31:0] BLTU  = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
    localparam logic [31:0] JALR1 = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
    localparam logic [31:0] JAL1  = {20'd0, 5'd1, 7'b1101111};
    localparam logic [31:0] ILL   = 32'h0000_007F;
    localparam logic [31:0] ADDI0 = {12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011};
    localparam logic [31:0] ADD9  = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd9, 7'b0110011};
    localparam logic [31:0] SW    = {7'b0000000, 5'd3, 5'd4, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] LUI   = {20'h12345, 5'd10, 7'b0110111};
    localparam logic [31:0] AUIPC = {20'h00001, 5'd11, 7'b0010111};
    logic clk = 1'b0, rst = 1'b0, ZeroE = 1'b0;
    logic [31:0] InstrD = NOP;
    logic [2:0] ImmSrcD, AddressingControlM, n_ImmSrcD, n_AddressingControlM;
    logic [3:0] ALUControlE, n_ALUControlE;
    logic [1:0] PCSrcE, ResultSrcW, ForwardAE, ForwardBE, n_PCSrcE, n_ResultSrcW, n_ForwardAE, n_ForwardBE;
    logic [4:0] RdW, n_RdW;
    logic ALUSrcAE, ALUSrcBE, MemWriteM, RegWriteW, StallF, StallD, FlushD, FlushE, IllegalE;
    logic n_ALUSrcAE, n_ALUSrcBE, n_MemWriteM, n_RegWriteW, n_StallF, n_StallD, n_FlushD, n_FlushE, n_IllegalE;
    logic [31:0] all_f, all_n;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    pipelined_control_path #(.REG_ADDR_W(5), .FORWARDING(1'b1)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ZeroE(ZeroE), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .PCSrcE(PCSrcE), .MemWriteM(MemWriteM),
        .AddressingControlM(AddressingControlM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .IllegalE(IllegalE)
    );
    pipelined_control_path #(.REG_ADDR_W(5), .FORWARDING(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ZeroE(ZeroE), .ImmSrcD(n_ImmSrcD), .ALUControlE(n_ALUControlE),
        .ALUSrcAE(n_ALUSrcAE), .ALUSrcBE(n_ALUSrcBE), .PCSrcE(n_PCSrcE), .MemWriteM(n_MemWriteM),
        .AddressingControlM(n_AddressingControlM), .RegWriteW(n_RegWriteW), .ResultSrcW(n_ResultSrcW), .RdW(n_RdW),
        .StallF(n_StallF), .StallD(n_StallD), .FlushD(n_FlushD), .FlushE(n_FlushE), .ForwardAE(n_ForwardAE),
        .ForwardBE(n_ForwardBE), .IllegalE(n_IllegalE)
    );
    assign all_f = {ImmSrcD, ALUControlE, ALUSrcAE, ALUSrcBE, PCSrcE, MemWriteM, AddressingControlM, RegWriteW,
                    ResultSrcW, RdW, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, IllegalE};
    assign all_n = {n_ImmSrcD, n_ALUControlE, n_ALUSrcAE, n_ALUSrcBE, n_PCSrcE, n_MemWriteM, n_AddressingControlM,
                    n_RegWriteW, n_ResultSrcW, n_RdW, n_StallF, n_StallD, n_FlushD, n_FlushE, n_ForwardAE,
                    n_ForwardBE, n_IllegalE};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [31:0] i);
        InstrD = i;
        #1;
    endtask
    task automatic drain;
        drive(NOP);
        repeat (3) tick();
    endtask
    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_all_fwd", all_f, 32'h0);
        check("reset_all_nofwd", all_n, 32'h0);
        #9 rst = 1'b0;
        tick();
        // back-to-back RAW: forward from M
        drive(ADD5);
        tick();
        drive(SUB6);
        check("b2b_no_stall_fwd", {31'b0, StallD}, 32'd0);
        tick();
        drive(NOP);
        check("b2b_fwd_ae_m", {30'b0, ForwardAE}, 32'd2);
        check("b2b_fwd_be", {30'b0, ForwardBE}, 32'd0);
        check("b2b_sub_alu", {28'b0, ALUControlE}, 32'd1);
        // one nop between: forward from W
        drive(ADD5);
        tick();
        drive(NOP);
        tick();
        drive(SUB6);
        tick();
        drive(NOP);
        check("gap_fwd_ae_w", {30'b0, ForwardAE}, 32'd1);
        check("gap_fwd_be", {30'b0, ForwardBE}, 32'd0);
        // no forwarding: two stall cycles
        drain();
        drive(ADD5);
        tick();
        drive(SUB6);
        check("nf_stall_c1", {29'b0, n_StallF, n_StallD, n_FlushE}, 32'h7);
        tick();
        check("nf_stall_c2", {29'b0, n_StallF, n_StallD, n_FlushE}, 32'h7);
        tick();
        check("nf_stall_c3", {29'b0, n_StallF, n_StallD, n_FlushE}, 32'h0);
        tick();
        drive(NOP);
        check("nf_sub_in_e", {28'b0, n_ALUControlE}, 32'd1);
        check("nf_fwd_zero", {28'b0, n_ForwardAE, n_ForwardBE}, 32'd0);
        // load-use
        drain();
        drive(LW7);
        tick();
        drive(ADD8);
        check("lu_stall", {28'b0, StallF, StallD, FlushE, FlushD}, 32'he);
        tick();
        check("lu_release", {28'b0, StallF, StallD, FlushE, FlushD}, 32'h0);
        check("lu_addr_m", {29'b0, AddressingControlM}, 32'd2);
        tick();
        drive(NOP);
        check("lu_fwd", {28'b0, ForwardAE, ForwardBE}, 32'h5);
        check("lu_w", {24'b0, RegWriteW, ResultSrcW, RdW}, {24'b0, 1'b1, 2'b01, 5'd7});
        // branches
        drive(BEQ);
        tick();
        drive(NOP);
        ZeroE = 1'b1;
        #1;
        check("beq_taken", {26'b0, PCSrcE, FlushD, FlushE, StallD, StallF}, {26'b0, 2'b01, 4'b1100});
        check("beq_alu", {28'b0, ALUControlE}, 32'd1);
        ZeroE = 1'b0;
        #1;
        check("beq_not_taken", {28'b0, PCSrcE, FlushD, FlushE}, 32'd0);
        drive(BGE);
        tick();
        drive(NOP);
        ZeroE = 1'b1;
        #1;
        check("bge_taken", {30'b0, PCSrcE}, 32'd1);
        check("bge_alu", {28'b0, ALUControlE}, 32'd8);
        ZeroE = 1'b0;
        #1;
        check("bge_not_taken", {30'b0, PCSrcE}, 32'd0);
        drive(BLTU);
        tick();
        drive(NOP);
        check("bltu_taken", {30'b0, PCSrcE}, 32'd1);
        check("bltu_alu", {28'b0, ALUControlE}, 32'd9);
        // flush beats stall (no-forwarding instance)
        drain();
        drive(ADD5);
        tick();
        drive(BEQ);
        tick();
        drive(SUB6);
        ZeroE = 1'b1;
        #1;
        check("nf_flush_over_stall", {28'b0, n_StallF, n_StallD, n_FlushD, n_FlushE}, 32'h3);
        ZeroE = 1'b0;
        #1;
        check("nf_stall_from_m", {28'b0, n_StallF, n_StallD, n_FlushD, n_FlushE}, 32'hd);
        // jalr / jal
        drain();
        drive(JALR1);
        check("jalr_imm", {29'b0, ImmSrcD}, 32'd0);
        tick();
        drive(NOP);
        check("jalr_pcsrc", {27'b0, PCSrcE, ALUSrcBE, FlushD, FlushE}, {27'b0, 2'b10, 3'b111});
        tick();
        tick();
        check("jalr_w", {24'b0, RegWriteW, ResultSrcW, RdW}, {24'b0, 1'b1, 2'b10, 5'd1});
        drive(JAL1);
        check("jal_imm", {29'b0, ImmSrcD}, 32'd3);
        tick();
        drive(NOP);
        check("jal_pcsrc", {30'b0, PCSrcE}, 32'd1);
        tick();
        // illegal opcode
        drive(ILL);
        check("ill_imm", {29'b0, ImmSrcD}, 32'd0);
        tick();
        drive(NOP);
        check("ill_e", {26'b0, IllegalE, ALUControlE, PCSrcE == 2'b00}, {26'b0, 1'b1, 4'd0, 1'b1});
        tick();
        check("ill_m", {30'b0, MemWriteM, IllegalE}, 32'd0);
        tick();
        check("ill_w", {26'b0, RegWriteW, RdW}, 32'd0);
        // store / lui / auipc
        drive(SW);
        check("sw_imm", {29'b0, ImmSrcD}, 32'd1);
        tick();
        drive(LUI);
        check("lui_imm", {29'b0, ImmSrcD}, 32'd4);
        check("sw_e", {27'b0, ALUControlE, ALUSrcBE}, {27'b0, 4'd0, 1'b1});
        tick();
        drive(AUIPC);
        check("sw_m", {28'b0, MemWriteM, AddressingControlM}, {28'b0, 1'b1, 3'b010});
        check("lui_e", {27'b0, ALUControlE, ALUSrcBE}, {27'b0, 4'd10, 1'b1});
        tick();
        drive(NOP);
        check("auipc_e", {30'b0, ALUSrcAE, ALUSrcBE}, 32'h3);
        // x0 never forwards or stalls
        drive(ADDI0);
        tick();
        drive(ADD9);
        check("x0_no_stall", {30'b0, StallD, n_StallD}, 32'd0);
        tick();
        drive(NOP);
        check("x0_no_fwd", {28'b0, ForwardAE, ForwardBE}, 32'd0);
        // async reset with a load in E
        drive(LW7);
        tick();
        drive(ADD8);
        check("rst_pre_stall", {31'b0, StallD}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_fwd", all_f, 32'h0);
        check("rst_async_nofwd", all_n, 32'h0);
        rst = 1'b0;
        #1;
        tick();
        check("rst_post", {26'b0, PCSrcE, StallF, StallD, FlushD, FlushE}, 32'd0);
        tick();
        check("rst_flow_add8", {28'b0, ALUControlE}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
